// File: rtl/dec_grant_arbiter.sv
// Four-client round-robin arbiter with a registered one-hot grant for a decoded shared resource.
// Optional hold-limit preemption is compiled in with `define ARB_HOLD_LIMIT_EN.
module dec_grant_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       preempt
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_max_hold_range
    $error("dec_grant_arbiter: MAX_HOLD must be in 1..255");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] idx_q, idx_d;
  logic       valid_q, valid_d;
  logic       preempt_q, preempt_d;

`ifdef ARB_HOLD_LIMIT_EN
  localparam logic [7:0] HOLD_SAT = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt_q, hold_cnt_d;
`endif

  logic       win_found;
  logic [1:0] win_idx;
  logic       owner_req;
  logic       others_pending;
  logic       take;

  // Scan from ptr downward in priority so the lowest offset from ptr is written last and wins.
  always_comb begin : winner_search
    win_found = 1'b0;
    win_idx   = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      if (req[ptr_q + 2'(i)]) begin
        win_found = 1'b1;
        win_idx   = ptr_q + 2'(i);
      end
    end
  end

  assign owner_req      = |(req & gnt_q);
  assign others_pending = |(req & ~gnt_q);

  always_comb begin : next_state
    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    preempt_d = 1'b0;
    take      = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
    hold_cnt_d = hold_cnt_q;
`endif

    if (!en) begin
      state_d = IDLE;
      gnt_d   = 4'b0000;
      idx_d   = 2'd0;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: take = win_found;
        GRANT: begin
          if (owner_req) begin
`ifdef ARB_HOLD_LIMIT_EN
            // ptr already points past the owner, so with others pending the winner is never the owner.
            if (others_pending && hold_cnt_q == HOLD_SAT) begin
              take      = 1'b1;
              preempt_d = 1'b1;
            end else if (hold_cnt_q != HOLD_SAT) begin
              hold_cnt_d = hold_cnt_q + 8'd1;
            end
`endif
          end else if (win_found) begin
            take = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            idx_d   = 2'd0;
            valid_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (take) begin
      state_d = GRANT;
      gnt_d   = 4'b0001 << win_idx;
      idx_d   = win_idx;
      valid_d = 1'b1;
      ptr_d   = win_idx + 2'd1;
`ifdef ARB_HOLD_LIMIT_EN
      hold_cnt_d = 8'd0;
`endif
    end
  end

`ifndef ARB_HOLD_LIMIT_EN
  logic unused_others;
  assign unused_others = others_pending;
`endif

  // NOTE: state uses non-blocking assignments so all flops update together from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd0;
      gnt_q      <= 4'b0000;
      idx_q      <= 2'd0;
      valid_q    <= 1'b0;
      preempt_q  <= 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
      hold_cnt_q <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      idx_q      <= idx_d;
      valid_q    <= valid_d;
      preempt_q  <= preempt_d;
`ifdef ARB_HOLD_LIMIT_EN
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;
  assign preempt   = preempt_q;

endmodule

// File: tb/tb_dec_grant_arbiter.sv
// Self-checking bench for dec_grant_arbiter: directed scenarios plus random traffic
// against a cycle-level ownership model (owner index, rotation point, cycles held).
module tb_dec_grant_arbiter;
  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  int n_checks = 0;
  int n_fail   = 0;

  int m_owner, m_ptr, m_held;
  bit m_pre;

  always #5 clk = ~clk;

  dec_grant_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .preempt(preempt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; req = 4'b0000;
    tick(); tick();
    rst = 1'b0;
  endtask

  function automatic int find_winner(logic [3:0] r, int p);
    for (int i = 0; i < 4; i++) begin
      if (r[(p + i) % 4]) return (p + i) % 4;
    end
    return -1;
  endfunction

  task automatic model_grant(int k);
    m_owner = k;
    m_ptr   = (k + 1) % 4;
    m_held  = 1;
  endtask

  // One clock edge of the arbiter's rules, applied to the inputs seen before that edge.
  task automatic model_step(input logic e, input logic [3:0] r);
    int w;
    m_pre = 1'b0;
    w = find_winner(r, m_ptr);
    if (!e) begin
      m_owner = -1;
    end else if (m_owner < 0) begin
      if (w >= 0) model_grant(w);
    end else if (!r[m_owner]) begin
      if (w >= 0) model_grant(w);
      else m_owner = -1;
    end else begin
`ifdef ARB_HOLD_LIMIT_EN
      if ((r & ~(4'b0001 << m_owner)) != 4'b0000 && m_held >= MAX_HOLD) begin
        model_grant(w);
        m_pre = 1'b1;
      end else begin
        m_held++;
      end
`endif
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; req = 4'b1111;
    tick();
    n_checks++;
    if ({gnt, gnt_idx, gnt_valid, preempt} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got gnt=%b idx=%0d valid=%b pre=%b, want all zero",
               gnt, gnt_idx, gnt_valid, preempt);
    end
    rst = 1'b0; en = 1'b0; req = 4'b0000;
  endtask

  task automatic test_single_request();
    do_reset();
    en = 1'b1; req = 4'b0100;
    #1;
    n_checks++;
    if (gnt !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_before_edge: gnt=%b, want 0000", gnt);
    end
    tick();
    n_checks++;
    if ({gnt, gnt_idx, gnt_valid} !== {4'b0100, 2'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL single_grant: gnt=%b idx=%0d valid=%b, want 0100 2 1", gnt, gnt_idx, gnt_valid);
    end
    req = 4'b0000;
    tick();
    req = 4'b1011;
    tick();
    n_checks++;
    if (gnt !== 4'b1000) begin
      n_fail++;
      $display("FAIL single_ptr_after: gnt=%b, want 1000 (search starts at 3)", gnt);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    en = 1'b1; req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (gnt !== exp_seq[i] || preempt !== 1'b0) begin
        n_fail++;
        $display("FAIL rotation_%0d: gnt=%b pre=%b, want %b 0", i, gnt, preempt, exp_seq[i]);
      end
      req = ~exp_seq[i];
    end
  endtask

  task automatic test_hold_limit();
    do_reset();
    en = 1'b1; req = 4'b0001;
    tick();
    req = 4'b1001;
`ifdef ARB_HOLD_LIMIT_EN
    for (int i = 0; i < MAX_HOLD; i++) begin
      n_checks++;
      if (gnt !== 4'b0001 || preempt !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_owner_cycle_%0d: gnt=%b pre=%b, want 0001 0", i, gnt, preempt);
      end
      tick();
    end
    n_checks++;
    if (gnt !== 4'b1000 || preempt !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_preempt: gnt=%b pre=%b, want 1000 1", gnt, preempt);
    end
    tick();
    n_checks++;
    if (gnt !== 4'b1000 || preempt !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_preempt_pulse: gnt=%b pre=%b, want 1000 0", gnt, preempt);
    end
`else
    begin
      int bad = 0;
      for (int i = 0; i < 100; i++) begin
        if (gnt !== 4'b0001 || preempt !== 1'b0) bad++;
        tick();
      end
      n_checks++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL nolimit_hold: %0d of 100 cycles lost ownership, want 0", bad);
      end
    end
    req = 4'b1000;
    tick();
    n_checks++;
    if (gnt !== 4'b1000 || preempt !== 1'b0) begin
      n_fail++;
      $display("FAIL nolimit_release: gnt=%b pre=%b, want 1000 0", gnt, preempt);
    end
`endif
  endtask

  task automatic test_enable_async_reset();
    do_reset();
    en = 1'b1; req = 4'b0010;
    tick();
    n_checks++;
    if (gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL en_grant: gnt=%b, want 0010", gnt);
    end
    en = 1'b0;
    tick();
    n_checks++;
    if ({gnt, gnt_idx, gnt_valid, preempt} !== 8'h00) begin
      n_fail++;
      $display("FAIL en_revoke: gnt=%b idx=%0d valid=%b pre=%b, want all zero",
               gnt, gnt_idx, gnt_valid, preempt);
    end
    en = 1'b1;
    tick();
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({gnt, gnt_idx, gnt_valid, preempt} !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset: gnt=%b idx=%0d valid=%b pre=%b, want all zero without an edge",
               gnt, gnt_idx, gnt_valid, preempt);
    end
    tick();
    rst = 1'b0; req = 4'b0011;
    tick();
    n_checks++;
    if (gnt !== 4'b0001 || gnt_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL post_reset_grant: gnt=%b idx=%0d, want 0001 0", gnt, gnt_idx);
    end
  endtask

  task automatic test_random();
    logic [3:0] exp_gnt;
    logic [1:0] exp_idx;
    do_reset();
    m_owner = -1; m_ptr = 0; m_held = 0; m_pre = 1'b0;
    for (int c = 0; c < 500; c++) begin
      en = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      model_step(en, req);
      tick();
      exp_gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      exp_idx = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
      n_checks++;
      if (gnt !== exp_gnt || gnt_idx !== exp_idx || gnt_valid !== (m_owner >= 0) || preempt !== m_pre) begin
        n_fail++;
        $display("FAIL random_cycle_%0d: got gnt=%b idx=%0d valid=%b pre=%b, want %b %0d %b %b",
                 c, gnt, gnt_idx, gnt_valid, preempt, exp_gnt, exp_idx, m_owner >= 0, m_pre);
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req = 4'b0000;
    test_reset();
    test_single_request();
    test_rotation();
    test_hold_limit();
    test_enable_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dec_grant_arbiter.md
# dec_grant_arbiter

Four-requester round-robin arbiter that shares a single 2-to-4 decoded resource, e.g. a bank of four select lines or a shared bus, between four clients. It picks one owner, drives the owner's index and a registered one-hot grant, holds the grant while the owner keeps requesting, and rotates fairly. An optional hold limit preempts an owner that monopolises the resource. It sits between the client request lines and the decoder-driven select/enable fabric.

## Interface
Parameters:
- MAX_HOLD, default 8: maximum consecutive grant cycles per ownership when the hold limit is compiled in. Legal range 1..255.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- en  input  1  arbiter enable, the E input of the decode; 0 revokes all grants.
- req  input  4  request per client; level-sensitive.
- gnt  output  4  registered one-hot grant. Always 0000 or exactly one bit set.
- gnt_idx  output  2  binary index of the owner; valid when gnt_valid=1, otherwise 0.
- gnt_valid  output  1  1 when gnt is nonzero.
- preempt  output  1  one-cycle pulse on the cycle a hold-limit rotation takes effect.

## Operation
- State machine:
  - Two states, IDLE and GRANT.
  - Internal round-robin pointer ptr[1:0] and hold counter hold_cnt[7:0].
- Winner search: the first set bit of req scanning ptr, ptr+1, ptr+2, ptr+3, with indices taken mod 4.
  - On any new grant to index k: ptr <= k+1 mod 4, hold_cnt <= 0.
- IDLE, with en=1 and req≠0: the next edge moves to GRANT with the winner's grant.
  - Otherwise the arbiter stays in IDLE with outputs 0.
- GRANT, owner o:
  - req[o]=1: keep o, and hold_cnt increments, saturating at MAX_HOLD-1.
  - req[o]=0 and other requests are pending: the next edge grants the next winner directly, with no idle cycle. The search starts at ptr = o+1.
  - req[o]=0 and no requests are pending: the next edge returns to IDLE and gnt becomes 0000.
  - en=0: the next edge returns to IDLE and all outputs become 0. ptr is kept.
- gnt = decode(gnt_idx) gated by gnt_valid. Implement as registered decode; the output must never carry two set bits, including through transitions.
- Simultaneous events:
  - Owner drop, new requests and hold-limit expiry in the same cycle are treated as a normal release. preempt stays 0.
  - en=0 has priority over all other events.
- Reset, including mid-grant: IDLE, ptr=0, hold_cnt=0. gnt=0000, gnt_idx=0, gnt_valid=0, preempt=0.

## Timing
- Latency from request to grant is 1 cycle. If req rises before edge N, gnt is visible after edge N.
- Release to next grant is 1 cycle: the edge that sees req[o]=0 installs the new owner.
- Hold limit:
  - An owner keeps the grant at most MAX_HOLD cycles while others are waiting.
  - The grant transfers at the edge where hold_cnt = MAX_HOLD-1 and another request is pending.
- preempt rises with the new gnt and lasts exactly 1 cycle.
- There is no combinational path from req or en to any output.

## Configuration
- ARB_HOLD_LIMIT_EN defined:
  - hold_cnt and the forced rotation are implemented.
  - While the owner's request stays high and no other request is pending, the owner keeps the grant indefinitely and hold_cnt stays saturated.
  - Rotation occurs on the first edge at which another request is seen.
- ARB_HOLD_LIMIT_EN undefined:
  - No counter is built, and MAX_HOLD is ignored.
  - The owner keeps the grant until it deasserts req or en=0.
  - preempt is tied to 0.

## Test plan
- Reset / single request: rst pulse, then req=0100 with en=1. gnt=0000 before the edge and 0100 after one edge; gnt_idx=2, gnt_valid=1. ptr becomes 3.
- Fair rotation: req=1111 constant, each owner drops req for one cycle after its grant. Grant order from reset is 0001, 0010, 0100, 1000, 0001, with no idle cycle between grants.
- Hold limit, with the macro defined and MAX_HOLD=4: client 0 holds req, client 3 requests from cycle 1. gnt=0001 for 4 cycles, then 1000 with preempt=1 for exactly 1 cycle.
- No limit, with the macro undefined: the same stimulus keeps gnt=0001 for 100 cycles with preempt=0. Client 0 then drops req, and gnt=1000 on the next edge.
- Enable and async reset: en falls mid-grant, giving gnt=0000 on the next edge. Then en=1 and rst is asserted between edges: outputs clear immediately without a clock edge, and after release req=0011 grants 0001.
